// File: rtl/clock_divider_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Optional tick outputs are enabled with the CLOCK_DIVIDER_TICK_EN macro.
package clock_divider_pkg;

    localparam int CNT_W_DEF = 28;
    localparam int MIN_DIV   = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] divisor;
        logic [CNT_W_DEF-1:0] high;
    } ch_cfg_t;

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: shadowed divisor/high-time, free-running counter and registered outputs.
// With CLOCK_DIVIDER_TICK_EN defined, a one-cycle tick aligned with each period start is added.
module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             in_clock,
    input  logic             in_reset_n,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] divisor_i,
    input  logic [CNT_W-1:0] high_i,
    output logic             out_clock_o,
`ifdef CLOCK_DIVIDER_TICK_EN
    output logic             out_tick_o,
`endif
    output logic             cfg_err_o
);

    logic [CNT_W-1:0] div_sh_q, div_sh_d;
    logic [CNT_W-1:0] high_sh_q, high_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             err_q, err_d;
    logic             run_q, run_d;
    logic             tick_q, tick_d;
    logic             run, valid, last, load;

    // The first enabled edge only restarts the phase, so the output rises one edge later.
    // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        run       = enable_i && run_q;
        valid     = div_sh_q >= CNT_W'(MIN_DIV);
        last      = cnt_q == (div_sh_q - CNT_W'(1));
        load      = !run || !valid || last;
        div_sh_d  = load ? divisor_i : div_sh_q;
        high_sh_d = load ? high_i    : high_sh_q;
        cnt_d     = (run && valid && !last) ? cnt_q + CNT_W'(1) : '0;
        clk_d     = run && valid && (cnt_q < high_sh_q);
        tick_d    = run && valid && (cnt_q == '0);
        err_d     = div_sh_d < CNT_W'(MIN_DIV);
        run_d     = enable_i;
    end

    // NOTE: sequential state uses non-blocking assignments and is cleared asynchronously.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            div_sh_q  <= '0;
            high_sh_q <= '0;
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_sh_q  <= div_sh_d;
            high_sh_q <= high_sh_d;
            cnt_q     <= cnt_d;
            clk_q     <= clk_d;
            err_q     <= err_d;
            run_q     <= run_d;
            tick_q    <= tick_d;
        end
    end

    assign out_clock_o = clk_q;
    assign cfg_err_o   = err_q;

`ifdef CLOCK_DIVIDER_TICK_EN
    assign out_tick_o = tick_q;
`else
    logic unused_tick;
    assign unused_tick = tick_q;
`endif

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider: NUM_CH independent channels sharing one source clock.
// Define CLOCK_DIVIDER_TICK_EN to add the per-channel out_tick output.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    in_clock,
    input  logic                    in_reset_n,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH*CNT_W-1:0] ch_divisor,
    input  logic [NUM_CH*CNT_W-1:0] ch_high,
    output logic [NUM_CH-1:0]       out_clock,
`ifdef CLOCK_DIVIDER_TICK_EN
    output logic [NUM_CH-1:0]       out_tick,
`endif
    output logic [NUM_CH-1:0]       cfg_err
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_divider_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .in_clock   (in_clock),
            .in_reset_n (in_reset_n),
            .enable_i   (ch_enable[g]),
            .divisor_i  (ch_divisor[g*CNT_W +: CNT_W]),
            .high_i     (ch_high[g*CNT_W +: CNT_W]),
            .out_clock_o(out_clock[g]),
`ifdef CLOCK_DIVIDER_TICK_EN
            .out_tick_o (out_tick[g]),
`endif
            .cfg_err_o  (cfg_err[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: expected per-cycle outputs are queued, then compared.
// Tick checks are compiled in when CLOCK_DIVIDER_TICK_EN is defined.
module tb_clock_divider_multi;
    import clock_divider_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = CNT_W_DEF;

    logic                    in_clock = 1'b0;
    logic                    in_reset_n;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH*CNT_W-1:0] ch_divisor;
    logic [NUM_CH*CNT_W-1:0] ch_high;
    logic [NUM_CH-1:0]       out_clock;
    logic [NUM_CH-1:0]       cfg_err;
    logic [NUM_CH-1:0]       tick_sig;

    clock_divider_multi #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W)
    ) dut (
        .in_clock  (in_clock),
        .in_reset_n(in_reset_n),
        .ch_enable (ch_enable),
        .ch_divisor(ch_divisor),
        .ch_high   (ch_high),
        .out_clock (out_clock),
`ifdef CLOCK_DIVIDER_TICK_EN
        .out_tick  (tick_sig),
`endif
        .cfg_err   (cfg_err)
    );

`ifndef CLOCK_DIVIDER_TICK_EN
    assign tick_sig = '0;
`endif

    always #5 in_clock = ~in_clock;

    typedef struct {
        int    cyc;
        int    ch;
        int    kind;   // 0 out_clock, 1 out_tick, 2 cfg_err
        logic  exp;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input int cyc, input int ch, input int kind, input logic exp, input string tag);
        exp_t e;
        e.cyc  = cyc;
        e.ch   = ch;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic run_sb(input string name);
        int   c;
        exp_t e;
        logic act;
        c = 0;
        while (sb.size() > 0) begin
            if (c > 2000) begin
                total++;
                bad++;
                $display("FAIL %s: scoreboard timeout, entries left=%0d required=0", name, sb.size());
                sb.delete();
                break;
            end
            @(posedge in_clock);
            #1;
            c++;
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                case (e.kind)
                    0:       act = out_clock[e.ch];
                    1:       act = tick_sig[e.ch];
                    default: act = cfg_err[e.ch];
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s/%s ch%0d cycle %0d: got %b required %b",
                             name, e.tag, e.ch, c, act, e.exp);
                end
            end
        end
    endtask

    task automatic set_ch(input int ch, input int div, input int high);
        ch_cfg_t cfg;
        cfg.divisor = CNT_W'(div);
        cfg.high    = CNT_W'(high);
        ch_divisor[ch*CNT_W +: CNT_W] = cfg.divisor;
        ch_high[ch*CNT_W +: CNT_W]    = cfg.high;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge in_clock);
        #1;
    endtask

    task automatic disable_all();
        ch_enable = '0;
        step(2);
    endtask

    task automatic test_reset();
        in_reset_n = 1'b0;
        ch_enable  = '0;
        ch_divisor = '0;
        ch_high    = '0;
        #12;
        total++;
        if (out_clock !== '0) begin
            bad++;
            $display("FAIL reset_out_clock: got %b required 0000", out_clock);
        end
        total++;
        if (cfg_err !== '0) begin
            bad++;
            $display("FAIL reset_cfg_err: got %b required 0000", cfg_err);
        end
        total++;
        if (tick_sig !== '0) begin
            bad++;
            $display("FAIL reset_tick: got %b required 0000", tick_sig);
        end
        #11;
        in_reset_n = 1'b1;
        step(1);
        // All divisors are 0 here, so every channel flags a configuration error once loaded.
        total++;
        if (cfg_err !== 4'b1111) begin
            bad++;
            $display("FAIL reset_first_load_err: got %b required 1111", cfg_err);
        end
    endtask

    task automatic test_basic();
        disable_all();
        set_ch(0, 4, 2);
        set_ch(1, 5, 2);
        set_ch(2, 2, 1);
        set_ch(3, 2, 1);
        ch_enable = 4'b0011;
        for (int k = 1; k <= 14; k++) begin
            push(k, 0, 0, (k >= 2) && (((k - 2) % 4) < 2), "div4_high2");
            push(k, 1, 0, (k >= 2) && (((k - 2) % 5) < 2), "div5_high2");
        end
        push(14, 0, 2, 1'b0, "div4_err");
        push(14, 1, 2, 1'b0, "div5_err");
        run_sb("basic");
    endtask

    task automatic test_midchange();
        disable_all();
        set_ch(0, 4, 2);
        ch_enable = 4'b0001;
        for (int k = 1; k <= 6; k++)
            push(k, 0, 0, (k >= 2) && (((k - 2) % 4) < 2), "before_change");
        run_sb("midchange_a");
        // Counter is at 1 now; the old 4-cycle period must finish before 6/3 applies.
        set_ch(0, 6, 3);
        push(1, 0, 0, 1'b1, "old_tail");
        push(2, 0, 0, 1'b0, "old_tail");
        push(3, 0, 0, 1'b0, "old_tail");
        for (int c = 4; c <= 15; c++)
            push(c, 0, 0, ((c - 4) % 6) < 3, "new_period");
        run_sb("midchange_b");
    endtask

    task automatic test_cfg_err();
        disable_all();
        set_ch(2, 1, 1);
        ch_enable = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            push(c, 2, 0, 1'b0, "div1_out");
            push(c, 2, 2, 1'b1, "div1_err");
        end
        run_sb("cfg_err_a");
        ch_enable = 4'b0000;
        set_ch(2, 2, 1);
        step(1);
        total++;
        if (cfg_err[2] !== 1'b0) begin
            bad++;
            $display("FAIL cfg_err_cleared: got %b required 0", cfg_err[2]);
        end
        ch_enable = 4'b0100;
        for (int c = 1; c <= 9; c++) begin
            push(c, 2, 0, (c >= 2) && (((c - 2) % 2) == 0), "div2_toggle");
            push(c, 2, 2, 1'b0, "div2_err");
        end
        run_sb("cfg_err_b");
    endtask

    task automatic test_const();
        disable_all();
        set_ch(0, 8, 0);
        set_ch(1, 8, 8);
        ch_enable = 4'b0011;
        for (int c = 1; c <= 26; c++) begin
            push(c, 0, 0, 1'b0, "high0_low");
            push(c, 1, 0, c >= 2, "high8_high");
        end
        run_sb("const");
    endtask

    task automatic test_reset_mid();
        disable_all();
        set_ch(0, 4, 2);
        set_ch(1, 8, 8);
        set_ch(3, 0, 0);
        ch_enable = 4'b1011;
        for (int k = 1; k <= 6; k++) begin
            push(k, 0, 0, (k >= 2) && (((k - 2) % 4) < 2), "pre_reset");
            push(k, 1, 0, k >= 2, "pre_reset_const");
            push(k, 3, 2, 1'b1, "pre_reset_err");
        end
        run_sb("reset_mid_a");
        #2;
        in_reset_n = 1'b0;
        #1;
        total++;
        if (out_clock !== '0) begin
            bad++;
            $display("FAIL reset_mid_out_clock: got %b required 0000", out_clock);
        end
        total++;
        if (cfg_err !== '0) begin
            bad++;
            $display("FAIL reset_mid_cfg_err: got %b required 0000", cfg_err);
        end
        #3;
        in_reset_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            push(c, 0, 0, (c >= 2) && (((c - 2) % 4) < 2), "post_reset");
            push(c, 1, 0, c >= 2, "post_reset_const");
            push(c, 3, 2, 1'b1, "post_reset_err");
        end
        run_sb("reset_mid_b");
    endtask

`ifdef CLOCK_DIVIDER_TICK_EN
    task automatic test_tick();
        disable_all();
        set_ch(0, 3, 1);
        ch_enable = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            push(c, 0, 1, (c >= 2) && (((c - 2) % 3) == 0), "tick_div3");
            push(c, 0, 0, (c >= 2) && (((c - 2) % 3) == 0), "clk_div3");
        end
        run_sb("tick_a");
        ch_enable = 4'b0000;
        for (int c = 1; c <= 8; c++)
            push(c, 0, 1, 1'b0, "tick_disabled");
        run_sb("tick_b");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_midchange();
        test_cfg_err();
        test_const();
        test_reset_mid();
`ifdef CLOCK_DIVIDER_TICK_EN
        test_tick();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
